maj_fold_serial: RTL and testbench

Folded, bit-serial majority evaluator. Accepts an N-bit vote vector in W-bit chunks over a valid/ready stream, accumulates the population count and returns the majority decision `y0 = (popcount >= (N+1)/2)`. It is the sequential, area-folded counterpart of the flat combinational majority trees: it consumes exactly the vectors those trees see, but serially, and answers on a handshaked result port.

---
 rtl/maj_fold_serial.sv | 162 ++++++++++++++++
 tb/tb_maj_fold_serial.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_fold_serial.sv
// Folded bit-serial majority evaluator: popcount of an N-bit vote vector streamed in W-bit beats.
// Optional `count` result port enabled by defining MAJ_COUNT_OUT_EN.
module maj_fold_serial #(
  parameter int N = 63,
  parameter int W = 9,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y0
`ifdef MAJ_COUNT_OUT_EN
  ,
  output logic [CW-1:0] count
`endif
);

  localparam int BEATS     = (N + W - 1) / W;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST_BITS = N - (BEATS - 1) * W;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] THRESH    = CW'((N + 1) / 2);

  if ((N % 2) == 0 || N < 3) begin : g_bad_n
    $error("maj_fold_serial: N must be odd and >= 3");
  end
  if (W < 1 || W > N) begin : g_bad_w
    $error("maj_fold_serial: W must satisfy 1 <= W <= N");
  end

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Positions past N only exist in the final beat and must never be counted.
  function automatic logic [W-1:0] mask_chunk(input logic [W-1:0] d, input logic last);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = d[i] & (~last | (i < LAST_BITS));
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] d);
    logic [CW-1:0] s;
    s = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      s = s + CW'(d[i]);
    end
    return s;
  endfunction

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          y0_q, y0_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
`ifdef MAJ_COUNT_OUT_EN
  logic [CW-1:0] count_q, count_d;
`endif

  logic          last_beat_s;
  logic [CW-1:0] chunk_pc_s;
  logic [CW-1:0] acc_next_s;

  // Next-state, accumulation and result capture.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    y0_d        = y0_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef MAJ_COUNT_OUT_EN
    count_d     = count_q;
`endif
    last_beat_s = (beat_q == LAST_BEAT);
    chunk_pc_s  = popcount(mask_chunk(in_data, last_beat_s));
    // Beat 0 loads rather than adds, so nothing from a prior vector leaks in.
    if (beat_q == {BW{1'b0}}) begin
      acc_next_s = chunk_pc_s;
    end else begin
      acc_next_s = acc_q + chunk_pc_s;
    end

    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d = acc_next_s;
          if (last_beat_s) begin
            beat_d      = {BW{1'b0}};
            y0_d        = (acc_next_s >= THRESH);
`ifdef MAJ_COUNT_OUT_EN
            count_d     = acc_next_s;
`endif
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          acc_d = acc_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = ACCUM;
        beat_d      = {BW{1'b0}};
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_q      <= {BW{1'b0}};
      acc_q       <= {CW{1'b0}};
      y0_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MAJ_COUNT_OUT_EN
      count_q     <= {CW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      y0_q        <= y0_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MAJ_COUNT_OUT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y0        = y0_q;
`ifdef MAJ_COUNT_OUT_EN
  assign count     = count_q;
`endif

endmodule

// File: tb/tb_maj_fold_serial.sv
// Bench for maj_fold_serial: W=9 and W=8 instances against a popcount reference model.
module tb_maj_fold_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel8, iv, orr;
  logic [8:0] id;
  logic       ir, ov, y;
  logic [5:0] c;

  logic       iv9, ir9, ov9, or9, y9;
  logic [8:0] id9;
  logic [5:0] c9;
  logic       iv8, ir8, ov8, or8, y8;
  logic [7:0] id8;
  logic [5:0] c8;

  assign iv9 = iv & ~sel8;
  assign or9 = orr & ~sel8;
  assign id9 = id;
  assign iv8 = iv & sel8;
  assign or8 = orr & sel8;
  assign id8 = id[7:0];
  assign ir  = sel8 ? ir8 : ir9;
  assign ov  = sel8 ? ov8 : ov9;
  assign y   = sel8 ? y8 : y9;
  assign c   = sel8 ? c8 : c9;

  maj_fold_serial #(.N(63), .W(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(ir9), .in_data(id9),
    .out_valid(ov9), .out_ready(or9), .y0(y9)
`ifdef MAJ_COUNT_OUT_EN
    , .count(c9)
`endif
  );

  maj_fold_serial #(.N(63), .W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .y0(y8)
`ifdef MAJ_COUNT_OUT_EN
    , .count(c8)
`endif
  );

`ifndef MAJ_COUNT_OUT_EN
  assign c9 = 6'd0;
  assign c8 = 6'd0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nres  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ov && orr) nres <= nres + 1;
  end

  // Reference: majority of the 63 real vote bits.
  function automatic int ref_cnt(input logic [63:0] v);
    return $countones(v[62:0]);
  endfunction

  // Streams one vector, optional gaps and result stalls; reports protocol health and result.
  task automatic drive_vec(input logic [63:0] v, input int gap_max, input int stall,
                           output bit proto_ok, output logic yo, output logic [5:0] co,
                           output int t_res);
    int nb;
    nb = sel8 ? 8 : 7;
    proto_ok = 1'b1;
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        iv = 1'b0;
        id = 9'($urandom);
        @(posedge clk); #1;
      end
      iv = 1'b1;
      id = sel8 ? {1'b0, v[k*8 +: 8]} : v[k*9 +: 9];
      if (ir !== 1'b1) proto_ok = 1'b0;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    if (ov !== 1'b1) proto_ok = 1'b0;
    yo = y;
    co = c;
    t_res = cyc;
    for (int s = 0; s < stall; s++) begin
      orr = 1'b0;
      iv  = 1'b1;
      id  = 9'($urandom);
      @(posedge clk); #1;
      if (ov !== 1'b1 || y !== yo || c !== co || ir !== 1'b0) proto_ok = 1'b0;
    end
    iv  = 1'b0;
    orr = 1'b1;
    @(posedge clk); #1;
    orr = 1'b0;
    if (ov !== 1'b0 || ir !== 1'b1) proto_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; iv = 1'b0; orr = 1'b0; sel8 = 1'b0; id = 9'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
    total++; if (y !== 1'b0) begin bad++; $display("FAIL reset_y0 got=%b exp=0", y); end
`ifdef MAJ_COUNT_OUT_EN
    total++; if (c !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", c); end
`endif
  endtask

  // Shared result check body kept inline per test through this macro-free pattern.
  task automatic test_vectors;
    logic [63:0] vecs [4];
    bit pk; logic yo; logic [5:0] co; int t; int e;
    vecs[0] = 64'd0;
    vecs[1] = {1'b0, {63{1'b1}}};
    vecs[2] = 64'h0000_0000_FFFF_FFFF;
    vecs[3] = 64'h0000_0000_7FFF_FFFF;
    sel8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_vec(vecs[i], 0, 0, pk, yo, co, t);
      e = ref_cnt(vecs[i]);
      total++; if (pk !== 1'b1) begin bad++; $display("FAIL vec%0d_protocol got=%b exp=1", i, pk); end
      total++; if (yo !== (e >= 32)) begin bad++; $display("FAIL vec%0d_y0 got=%b exp=%b", i, yo, (e >= 32)); end
`ifdef MAJ_COUNT_OUT_EN
      total++; if (co !== 6'(e)) begin bad++; $display("FAIL vec%0d_count got=%0d exp=%0d", i, co, e); end
`endif
    end
  endtask

  task automatic test_backpressure;
    bit pk; logic yo; logic [5:0] co; int t;
    sel8 = 1'b0;
    drive_vec(64'h0000_0000_FFFF_FFFF, 0, 5, pk, yo, co, t);
    total++; if (pk !== 1'b1) begin bad++; $display("FAIL bp_protocol got=%b exp=1", pk); end
    total++; if (yo !== 1'b1) begin bad++; $display("FAIL bp_y0 got=%b exp=1", yo); end
`ifdef MAJ_COUNT_OUT_EN
    total++; if (co !== 6'd32) begin bad++; $display("FAIL bp_count got=%0d exp=32", co); end
`endif
  endtask

  task automatic test_reset_mid;
    bit pk; logic yo; logic [5:0] co; int t;
    logic [63:0] v;
    sel8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; id = 9'h1FF;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    rst = 1'b1;
    #2;
    total++; if (ov !== 1'b0 || ir !== 1'b1) begin bad++; $display("FAIL rstmid_outputs got=%b%b exp=01", ov, ir); end
    rst = 1'b0;
    @(posedge clk); #1;
    drive_vec(64'd0, 0, 0, pk, yo, co, t);
    total++; if (pk !== 1'b1) begin bad++; $display("FAIL rstmid_protocol got=%b exp=1", pk); end
    total++; if (yo !== 1'b0) begin bad++; $display("FAIL rstmid_y0 got=%b exp=0", yo); end
`ifdef MAJ_COUNT_OUT_EN
    total++; if (co !== 6'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", co); end
`endif
    // Second partial vector then reset: 27 stale ones must not add to the next 27.
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; id = 9'h1FF;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    v = 64'd0;
    v[26:0] = 27'h7FF_FFFF;
    drive_vec(v, 0, 0, pk, yo, co, t);
    total++; if (yo !== 1'b0) begin bad++; $display("FAIL rstmid2_y0 got=%b exp=0", yo); end
`ifdef MAJ_COUNT_OUT_EN
    total++; if (co !== 6'd27) begin bad++; $display("FAIL rstmid2_count got=%0d exp=27", co); end
`endif
  endtask

  task automatic test_masking;
    bit pk; logic yo; logic [5:0] co; int t;
    sel8 = 1'b1;
    drive_vec({64{1'b1}}, 0, 0, pk, yo, co, t);
    total++; if (pk !== 1'b1) begin bad++; $display("FAIL mask_protocol got=%b exp=1", pk); end
    total++; if (yo !== 1'b1) begin bad++; $display("FAIL mask_y0 got=%b exp=1", yo); end
`ifdef MAJ_COUNT_OUT_EN
    total++; if (co !== 6'd63) begin bad++; $display("FAIL mask_count got=%0d exp=63", co); end
`endif
    sel8 = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit pk; logic yo; logic [5:0] co; int t; int t_prev;
    logic [63:0] v;
    sel8 = 1'b0;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      drive_vec(v, 0, 0, pk, yo, co, t);
      total++; if (yo !== (ref_cnt(v) >= 32)) begin bad++; $display("FAIL b2b%0d_y0 got=%b exp=%b", i, yo, (ref_cnt(v) >= 32)); end
      if (i > 0) begin
        total++; if (t - t_prev !== 8) begin bad++; $display("FAIL b2b%0d_period got=%0d exp=8", i, t - t_prev); end
      end
      t_prev = t;
    end
  endtask

  task automatic test_random;
    bit pk; logic yo; logic [5:0] co; int t; int e; int n0; int k;
    logic [63:0] v;
    n0 = nres;
    for (int i = 0; i < 40; i++) begin
      sel8 = 1'($urandom_range(1, 0));
      case ($urandom_range(2, 0))
        0: v = {$urandom, $urandom};
        1: begin
          k = int'($urandom_range(35, 28));
          v = {64{1'b1}} >> (64 - k);
        end
        default: v = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      v[63] = 1'($urandom);
      e = ref_cnt(v);
      drive_vec(v, 2, int'($urandom_range(3, 0)), pk, yo, co, t);
      total++; if (pk !== 1'b1) begin bad++; $display("FAIL rnd%0d_protocol got=%b exp=1", i, pk); end
      total++; if (yo !== (e >= 32)) begin bad++; $display("FAIL rnd%0d_y0 got=%b exp=%b", i, yo, (e >= 32)); end
`ifdef MAJ_COUNT_OUT_EN
      total++; if (co !== 6'(e)) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", i, co, e); end
`endif
    end
    total++; if (nres - n0 !== 40) begin bad++; $display("FAIL rnd_result_count got=%0d exp=40", nres - n0); end
    sel8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_masking();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
